// File: rtl/uart_traffic_gen.sv
// UART traffic source: counter, PRBS or FIFO-echo characters handed to a uart_tx-style core.
// Define UART_TRAFFIC_STATS_EN to add the o_tx_count / o_drop_count statistics outputs.
module uart_traffic_gen #(
   parameter int          DATA_W     = 8,
   parameter int          INTERVAL   = 20000,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] PRBS_SEED  = 16'hACE1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_run,
   input  logic [1:0]                    i_mode,
   input  logic [DATA_W-1:0]             i_rx_data,
   input  logic                          i_rx_valid,
   input  logic                          i_tx_busy,
   output logic [DATA_W-1:0]             o_tx_data,
   output logic                          o_tx_en,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic                          o_overflow
`ifdef UART_TRAFFIC_STATS_EN
   ,
   output logic [31:0]                   o_tx_count,
   output logic [15:0]                   o_drop_count
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

   localparam logic [1:0] MODE_CNT  = 2'd0;
   localparam logic [1:0] MODE_PRBS = 2'd1;
   localparam logic [1:0] MODE_ECHO = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      GAP,
      LAUNCH,
      WAIT_ACK,
      WAIT_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          mode_q, mode_d;
   logic [CW-1:0]       gap_q, gap_d;
   logic [DATA_W-1:0]   cnt_q, cnt_d;
   logic [15:0]         lfsr_q, lfsr_d;
   logic                tx_en_q, tx_en_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]       level_q, level_d;
   logic                ovf_q, ovf_d;
   logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];

   logic                fifo_full;
   logic                fifo_empty;
   logic                push;
   logic                pop;
   logic [DATA_W-1:0]   src_data;

   assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
   assign fifo_empty = (level_q == '0);
   assign push       = i_rx_valid && !fifo_full;

   always_comb begin
      src_data = fifo_mem_q[rd_ptr_q];
      case (mode_q)
         MODE_CNT:  src_data = cnt_q;
         MODE_PRBS: src_data = lfsr_q[DATA_W-1:0];
         default:   src_data = fifo_mem_q[rd_ptr_q];
      endcase
   end

   // Mode is sampled only when leaving IDLE so a character in flight always completes.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      gap_d     = gap_q;
      cnt_d     = cnt_q;
      lfsr_d    = lfsr_q;
      tx_en_d   = 1'b0;
      tx_data_d = tx_data_q;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_run) begin
               if (i_mode == MODE_CNT || i_mode == MODE_PRBS) begin
                  mode_d  = i_mode;
                  gap_d   = '0;
                  state_d = GAP;
               end else if (i_mode == MODE_ECHO && !fifo_empty) begin
                  mode_d  = i_mode;
                  state_d = LAUNCH;
               end
            end
         end
         GAP: begin
            if (!i_run) begin
               gap_d   = '0;
               state_d = IDLE;
            end else if (gap_q == CW'(INTERVAL - 1)) begin
               gap_d   = '0;
               state_d = LAUNCH;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         LAUNCH: begin
            if (!i_tx_busy) begin
               tx_en_d   = 1'b1;
               tx_data_d = src_data;
               pop       = (mode_q == MODE_ECHO) && !fifo_empty;
               state_d   = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (i_tx_busy) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!i_tx_busy) begin
               if (mode_q == MODE_CNT) begin
                  cnt_d = cnt_q + 1'b1;
               end else if (mode_q == MODE_PRBS) begin
                  lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Push and pop in the same cycle both take effect and leave the level unchanged.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d  = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
      ovf_d = ovf_q | (i_rx_valid & fifo_full);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         mode_q    <= MODE_CNT;
         gap_q     <= '0;
         cnt_q     <= '0;
         lfsr_q    <= PRBS_SEED;
         tx_en_q   <= 1'b0;
         tx_data_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         gap_q     <= gap_d;
         cnt_q     <= cnt_d;
         lfsr_q    <= lfsr_d;
         tx_en_q   <= tx_en_d;
         tx_data_q <= tx_data_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         ovf_q     <= ovf_d;
      end
   end

   // Storage needs no reset; emptiness is tracked entirely by the pointers and level.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= i_rx_data;
      end
   end

   assign o_tx_en      = tx_en_q;
   assign o_tx_data    = tx_data_q;
   assign o_fifo_level = level_q;
   assign o_overflow   = ovf_q;

`ifdef UART_TRAFFIC_STATS_EN
   logic [31:0] tx_count_q, tx_count_d;
   logic [15:0] drop_count_q, drop_count_d;

   always_comb begin
      tx_count_d   = tx_en_d ? tx_count_q + 32'd1 : tx_count_q;
      drop_count_d = drop_count_q;
      if (i_rx_valid && fifo_full && drop_count_q != 16'hFFFF) begin
         drop_count_d = drop_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_count_q   <= '0;
         drop_count_q <= '0;
      end else begin
         tx_count_q   <= tx_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign o_tx_count   = tx_count_q;
   assign o_drop_count = drop_count_q;
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/uart_traffic_gen.md
# uart_traffic_gen

Parametrised UART traffic source that drives a `uart_tx`-style transmitter. It selects between three run-time modes: incrementing-counter pattern, PRBS pattern, and echo of bytes from a `uart_rx`-style receiver through an internal FIFO. It generalises the fixed counter-every-N-cycles loop test, adding configurable spacing, width, buffering and busy-aware handshaking, and sits between the board-level UART pins' rx/tx cores and the top level.

## Interface
- `DATA_W`, 8: character width, 5..16.
- `INTERVAL`, 20000: idle gap in clocks between pattern characters, ≥1.
- `FIFO_DEPTH`, 16: echo FIFO entries, power of 2, ≥2.
- `PRBS_SEED`, 16'hACE1: LFSR reset value, non-zero.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `i_run` in 1: 1 = generator active; 0 = finish current character, then idle.
- `i_mode` in 2: 0 counter, 1 PRBS, 2 echo, 3 reserved (treated as idle).
- `i_rx_data` in DATA_W: received character.
- `i_rx_valid` in 1: one-cycle strobe qualifying `i_rx_data`.
- `i_tx_busy` in 1: transmitter busy.
- `o_tx_data` out DATA_W: character to send, stable from `o_tx_en` until `i_tx_busy` falls.
- `o_tx_en` out 1: one-cycle start strobe.
- `o_fifo_level` out $clog2(FIFO_DEPTH)+1: echo FIFO occupancy.
- `o_overflow` out 1: sticky, set when a received character is dropped because the FIFO is full.

## Operation
- FSM states: IDLE, GAP, LAUNCH, WAIT_ACK, WAIT_DONE.
- IDLE: latches `i_mode` on exit. If `i_run`=1, mode 0/1 goes to GAP, and mode 2 with FIFO non-empty goes to LAUNCH. Otherwise it stays in IDLE.
- GAP: the gap counter counts 0..INTERVAL-1, then goes to LAUNCH. If `i_run` drops, it returns to IDLE and the counter clears.
- LAUNCH: entered only with `i_tx_busy`=0, otherwise waits here.
  - Drives `o_tx_en`=1 for exactly one cycle.
  - `o_tx_data` = counter value, LFSR low DATA_W bits, or FIFO head.
  - In echo mode, pops the FIFO in the same cycle.
  - Next state: WAIT_ACK.
- WAIT_ACK: waits for `i_tx_busy`=1, then goes to WAIT_DONE. There is no timeout.
- WAIT_DONE: waits for `i_tx_busy`=0. Then it advances the pattern source and returns to IDLE.
  - Counter: +1, wraps 2^DATA_W-1 → 0.
  - PRBS: one LFSR step.
- Mode changes take effect only in IDLE. A character in flight always completes.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shift left, feedback into bit 0.
- FIFO:
  - Push on `i_rx_valid` when not full, in all modes and regardless of `i_run`.
  - A push while full is dropped and sets `o_overflow`.
  - Simultaneous push and pop: level is unchanged, both take effect.
  - A push to an empty FIFO is poppable the next cycle.
- `o_overflow` clears only on reset.

## Timing
- Reset values: `o_tx_en`=0, `o_tx_data`=0, `o_fifo_level`=0, `o_overflow`=0, FSM=IDLE, counter=0, LFSR=PRBS_SEED, FIFO empty.
- Pattern modes: exactly INTERVAL+1 clocks run from IDLE exit to the `o_tx_en` pulse, plus any busy stall in LAUNCH.
- Echo mode: `o_tx_en` rises 2 clocks after the `i_rx_valid` that fills an empty FIFO, if the FSM is in IDLE with `i_run`=1.
- All outputs are registered. `o_fifo_level` updates the cycle after a push or pop.
- Reset asserted mid-operation: all state returns to reset values immediately. Buffered FIFO data is discarded.

## Configuration
- `UART_TRAFFIC_STATS_EN` defined: adds outputs `o_tx_count` (32-bit, +1 per `o_tx_en`) and `o_drop_count` (16-bit, +1 per dropped push, saturating at 16'hFFFF). Both reset to 0.
- Undefined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- Counter mode, INTERVAL=10, transmitter model holding busy 5 clocks:
  - first `o_tx_en` 11 clocks after `i_run` rises, data 8'h00;
  - next characters 8'h01, 8'h02;
  - after 8'hFF, wraps to 8'h00.
- PRBS mode, seed 16'hACE1: first three characters match the golden LFSR model (low byte E1, then successive steps). Reset mid-run restores E1 as the next character.
- Echo mode: inject 8'h55, 8'hAA, 8'h3C on back-to-back `i_rx_valid` → transmitted in the same order, and `o_fifo_level` peaks at 3 (or 2 if a pop overlaps).
- Overflow, FIFO_DEPTH=4, busy held high:
  - inject 6 characters → `o_fifo_level`=4 and `o_overflow`=1;
  - after busy releases, only the first 4 are sent;
  - with STATS_EN, `o_drop_count`=2.
- `i_tx_busy` already high in LAUNCH → `o_tx_en` is withheld until busy falls, then pulses exactly once.
- Mode switched 0→2 during WAIT_DONE → the current counter character completes, and the next character comes from the FIFO.
